// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed BCD seven-segment scan controller.
//   A prescaler divides clk into digit slots of REFRESH_DIV cycles; a digit index steps
//   through NUM_DIGITS slots per frame. New digit data is captured into a staging register
//   on load and promoted to the display register only at a frame boundary, so a frame never
//   shows a mix of old and new digits.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bcd_in     - BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   dp_in      - decimal point request per digit (active-high)
//   load       - capture strobe for bcd_in/dp_in
//   lz_en      - leading-zero blanking enable
//   seven      - segments a..g (bit6 = a, bit0 = g)
//   dp         - decimal point segment
//   an         - digit enables, bit i = digit i
//   frame_done - one-cycle pulse after each full scan
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 4096,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [6:0]              seven,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEVEN_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF      = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF      = AN_ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_stage_bcd;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_bcd;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic                    r_frame_done;
    logic [6:0]              r_seven;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic                    w_boundary;
    logic                    w_slot_start;
    logic [3:0]              w_digit;
    logic                    w_dp_bit;
    logic                    w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_seg_al;

    // Active-low a..g pattern; codes 10..15 blank.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b0000001;
            4'd1:    f_decode = 7'b1001111;
            4'd2:    f_decode = 7'b0010010;
            4'd3:    f_decode = 7'b0000110;
            4'd4:    f_decode = 7'b1001100;
            4'd5:    f_decode = 7'b0100100;
            4'd6:    f_decode = 7'b0100000;
            4'd7:    f_decode = 7'b0001111;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0000100;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_boundary   = w_tick && (r_idx == IDX_LAST);
    assign w_slot_start = (r_presc == '0);

    // Select the current digit and decide whether it is a leading zero. The scan runs from
    // the top digit down, tracking whether every digit at or above i is zero.
    always_comb begin
        logic v_all_zero;
        w_digit    = '0;
        w_dp_bit   = 1'b0;
        w_lz_blank = 1'b0;
        w_onehot   = '0;
        v_all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_all_zero = v_all_zero && (r_disp_bcd[4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_digit     = r_disp_bcd[4*i +: 4];
                w_dp_bit    = r_disp_dp[i];
                w_lz_blank  = lz_en && v_all_zero && (i != 0);
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_seg_al = w_lz_blank ? 7'h7F : f_decode(w_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_stage_bcd  <= '0;
            r_stage_dp   <= '0;
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_seven      <= SEVEN_OFF;
            r_dp         <= DP_OFF;
            r_an         <= AN_OFF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= w_boundary ? '0 : r_idx + 1'b1;
            end

            if (load) begin
                r_stage_bcd <= bcd_in;
                r_stage_dp  <= dp_in;
            end
            // A load on the boundary edge promotes the previous staging contents; the new
            // data stays pending for the following frame.
            if (w_boundary && r_pending) begin
                r_disp_bcd <= r_stage_bcd;
                r_disp_dp  <= r_stage_dp;
            end
            r_pending    <= load | (r_pending & ~w_boundary);
            r_frame_done <= w_boundary;

            // Outputs lag the prescaler by one cycle: prescaler value 0 yields the dark
            // first cycle of each slot. The segment pattern is latched once per slot so a
            // change of lz_en lands on a slot start.
            if (w_slot_start) begin
                r_seven <= SEG_ACTIVE_LOW ? w_seg_al : ~w_seg_al;
                r_an    <= AN_OFF;
                r_dp    <= DP_OFF;
            end else begin
                r_an    <= AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
                r_dp    <= SEG_ACTIVE_LOW ? ~w_dp_bit : w_dp_bit;
            end
        end
    end

    assign seven      = r_seven;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  seven;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    logic [15:0] bcd2 = '0;
    logic [3:0]  dpi2 = '0;
    logic        load2 = 1'b0;
    logic        lz2 = 1'b0;
    logic [6:0]  seven2;
    logic        dp2;
    logic [3:0]  an2;
    logic        fd2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .seven(seven), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd2), .dp_in(dpi2), .load(load2),
        .lz_en(lz2), .seven(seven2), .dp(dp2), .an(an2), .frame_done(fd2)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dpi;
        logic        lz;
        logic [27:0] seg;  // expected seven per digit, digit i at [7i+6:7i]
        logic [3:0]  dpo;  // expected dp output per digit
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [15:0] b, input logic [3:0] d, input logic lz);
        bcd_in = b;
        dp_in  = d;
        lz_en  = lz;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " frame_done seen"}, 32'(got), 32'd1);
    endtask

    // Entered in the cycle frame_done is high; checks one whole frame and ends in the next
    // frame_done cycle.
    task automatic check_frame(input logic [27:0] seg, input logic [3:0] dpo, input string tag);
        int         pulses = 0;
        logic [3:0] oh;
        logic [3:0] exp_an;
        for (int k = 1; k <= 16; k++) begin
            int s;
            int ph;
            step();
            s  = (k - 1) / 4;
            ph = (k - 1) % 4;
            oh = 4'b0001 << s;
            exp_an = ~oh;
            if (ph == 0) begin
                chk($sformatf("%s slot%0d an dark", tag, s), 32'(an), 32'hF);
                chk($sformatf("%s slot%0d dp dark", tag, s), 32'(dp), 32'd1);
            end else begin
                chk($sformatf("%s slot%0d an", tag, s), 32'(an), 32'(exp_an));
            end
            if (ph == 2) begin
                chk($sformatf("%s digit%0d seven", tag, s), 32'(seven), 32'(seg[7*s +: 7]));
                chk($sformatf("%s digit%0d dp", tag, s), 32'(dp), 32'(dpo[s]));
            end
            if (k < 16 && frame_done) pulses++;
        end
        chk({tag, " frame_done at frame end"}, 32'(frame_done), 32'd1);
        chk({tag, " no stray frame_done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [3:0] got2;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'h9A5F, 4'b0100, 1'b0,
                    {7'b0000100, 7'b1111111, 7'b0100100, 7'b1111111}, 4'b1011};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0,
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
        vecs[5] = '{16'h0000, 4'b1111, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0000};
        vecs[6] = '{16'h8065, 4'b1000, 1'b1,
                    {7'b0000000, 7'b0000001, 7'b0100000, 7'b0100100}, 4'b0111};

        // Reset state, both polarities
        #1 rst_n = 1'b0;
        #1;
        chk("reset an", 32'(an), 32'hF);
        chk("reset seven", 32'(seven), 32'h7F);
        chk("reset dp", 32'(dp), 32'd1);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset hi an", 32'(an2), 32'h0);
        chk("reset hi seven", 32'(seven2), 32'h0);
        chk("reset hi dp", 32'(dp2), 32'd0);
        chk("reset hi frame_done", 32'(fd2), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge dark, digit 0 from edge 2 showing the zeroed display
        step();
        chk("post-reset edge1 an", 32'(an), 32'hF);
        step();
        chk("post-reset edge2 an", 32'(an), 32'hE);
        chk("post-reset edge2 seven", 32'(seven), 32'h01);
        chk("post-reset edge2 dp", 32'(dp), 32'd1);
        chk("post-reset hi an", 32'(an2), 32'h1);
        chk("post-reset hi seven", 32'(seven2), 32'h7E);

        for (int v = 0; v < 7; v++) begin
            load_val(vecs[v].bcd, vecs[v].dpi, vecs[v].lz);
            wait_frame($sformatf("vec%0d", v));
            check_frame(vecs[v].seg, vecs[v].dpo, $sformatf("vec%0d", v));
        end

        // Mid-frame load: rest of the current frame keeps the 8065 contents
        repeat (5) step();
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk("midload digit1 an", 32'(an), 32'hD);
        chk("midload digit1 seven old", 32'(seven), 32'(7'b0100000));
        repeat (4) step();
        chk("midload digit2 an", 32'(an), 32'hB);
        chk("midload digit2 seven old", 32'(seven), 32'(7'b0000001));
        wait_frame("midload");
        check_frame(vecs[0].seg, 4'b1111, "midload new");

        // Load on the boundary edge: staged 5678 shows first, 9999 the frame after
        load_val(16'h5678, 4'b0000, 1'b0);
        repeat (14) step();
        bcd_in = 16'h9999;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk("bndload edge is boundary", 32'(frame_done), 32'd1);
        check_frame({7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'b1111, "bndload old");
        check_frame({4{7'b0000100}}, 4'b1111, "bndload new");

        // Asynchronous reset mid-slot, then rescan from digit 0 with cleared display
        step();
        step();
        chk("pre-reset an digit0", 32'(an), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset an", 32'(an), 32'hF);
        chk("async reset seven", 32'(seven), 32'h7F);
        chk("async reset dp", 32'(dp), 32'd1);
        chk("async reset hi an", 32'(an2), 32'h0);
        chk("async reset hi seven", 32'(seven2), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rescan edge1 an", 32'(an), 32'hF);
        step();
        chk("rescan edge2 an", 32'(an), 32'hE);
        chk("rescan edge2 seven", 32'(seven), 32'h01);

        // Active-high instance: digit 8 lights every segment, one-hot high enables
        bcd2  = 16'h8888;
        dpi2  = 4'b0001;
        load2 = 1'b1;
        step();
        load2 = 1'b0;
        got2 = 4'd0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (fd2) begin
                got2 = 4'd1;
                break;
            end
        end
        chk("hi frame_done seen", 32'(got2), 32'd1);
        step();
        chk("hi slot0 an dark", 32'(an2), 32'h0);
        chk("hi slot0 dp dark", 32'(dp2), 32'd0);
        step();
        chk("hi digit0 an", 32'(an2), 32'h1);
        chk("hi digit0 seven", 32'(seven2), 32'h7F);
        chk("hi digit0 dp", 32'(dp2), 32'd1);
        repeat (4) step();
        chk("hi digit1 an", 32'(an2), 32'h2);
        chk("hi digit1 seven", 32'(seven2), 32'h7F);
        chk("hi digit1 dp", 32'(dp2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
